seq_det_arbiter: RTL

SEQ_DET_ARBITER -- requirements
Module: seq_det_arbiter

---
 rtl/seq_det_arbiter_if.sv | 24 ++
 rtl/seq_det_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_det_arbiter_if.sv
// Two-requester word handshake bundle between the requesters and the arbiter.
// Each requester holds valid/data; the arbiter answers with a one-cycle ready.
interface seq_det_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;

  // Requester side: offers words and watches for acceptance.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  // Arbiter side: observes offers and grants one at a time.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/seq_det_arbiter.sv
// Round-robin arbiter that serializes one granted word MSB-first into an
// external sequence detector and counts detector matches per requester.
// Flow per word: IDLE (grant) -> CLR -> SHIFT x WIDTH -> FLUSH -> DONE.
module seq_det_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  seq_det_arbiter_if.slave req,
  output logic             det_clr,
  output logic             det_x,
  input  logic             det_z,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] match0_cnt,
  output logic [CNT_W-1:0] match1_cnt,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  localparam int                IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             done_id_q, done_id_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             any_req;
  logic             pick;
  logic             window;

  // Round-robin choice: on contention take the requester not granted last.
  always_comb begin
    any_req = req.req0_valid | req.req1_valid;
    if (req.req0_valid && req.req1_valid) pick = ~last_q;
    else                                  pick = req.req1_valid;
  end

  // Next-state and per-state outputs of the word sequencer.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    data_d         = data_q;
    idx_d          = idx_q;
    gnt_d          = gnt_q;
    last_d         = last_q;
    done_id_d      = done_id_q;
    req.req0_ready = 1'b0;
    req.req1_ready = 1'b0;
    det_clr        = 1'b0;
    det_x          = 1'b0;
    done           = 1'b0;
    window         = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ready is gated by reset so a held reset never shows a grant.
        if (any_req && !reset) begin
          req.req0_ready = ~pick;
          req.req1_ready = pick;
          gnt_d          = pick;
          data_d         = pick ? req.req1_data : req.req0_data;
          state_d        = CLR;
        end
      end
      CLR: begin
        det_clr = 1'b1;
        idx_d   = IDX_LAST;
        state_d = SHIFT;
      end
      SHIFT: begin
        det_x = data_q[idx_q];
        // The first shifted bit has no detector response yet; counting starts one cycle later.
        window = (idx_q != IDX_LAST);
        idx_d  = idx_q - IDX_W'(1);
        if (idx_q == '0) state_d = FLUSH;
      end
      FLUSH: begin
        // Detector answer to the final bit arrives here.
        window  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done      = 1'b1;
        last_d    = gnt_q;
        done_id_d = gnt_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating match counters; a clear wins over a coincident increment.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (window && det_z) begin
      if (!gnt_q && cnt0_q != CNT_MAX) cnt0_d = cnt0_q + CNT_W'(1);
      if ( gnt_q && cnt1_q != CNT_MAX) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  // State register; reset aborts any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      gnt_q     <= 1'b0;
      // Pretend requester 1 went last so requester 0 wins the first contention.
      last_q    <= 1'b1;
      done_id_q <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the same pre-edge values.
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      done_id_q <= done_id_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done_id    = (state_q == DONE) ? gnt_q : done_id_q;
  assign match0_cnt = cnt0_q;
  assign match1_cnt = cnt1_q;

endmodule
